// File: rtl/pixel_sink.sv
`default_nettype none
// ============================================================================
// pixel_sink: FIFO-buffered pixel writes into a 1-bpp framebuffer, arbitrated
// against scanout reads and a full-screen clear engine.   Revision: 1.0
// ============================================================================
module pixel_sink #(
   parameter int FB_WIDTH   = 160,
   parameter int FB_HEIGHT  = 120,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pixel_en,
   input  logic [31:0]                   pixel_addr,
   input  logic                          pixel_value,
   output logic                          stall,
   input  logic                          clear_req,
   output logic                          busy,
   input  logic                          scan_en,
   input  logic [ADDR_W-1:0]             scan_addr,
   output logic                          scan_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          oob_err,
   output logic                          overflow_err
);
   localparam int                 FB_SIZE   = FB_WIDTH * FB_HEIGHT;
   localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                 CNT_W     = PTR_W + 1;
   localparam logic [31:0]        FB_SIZE_W = 32'(FB_SIZE);
   localparam logic [ADDR_W-1:0]  FB_SIZE_A = ADDR_W'(FB_SIZE);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FB_SIZE - 1);
   localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                scan_data_q, scan_data_d;
   logic                oob_q, oob_d;
   logic                ovf_q, ovf_d;

   logic [31:0]         fifo_addr_q [FIFO_DEPTH];
   logic                fifo_val_q  [FIFO_DEPTH];
   logic                fb_mem      [FB_SIZE];

   logic                full;
   logic                push;
   logic                pop;
   logic [31:0]         head_addr;
   logic                head_val;
   logic                fb_we;
   logic [ADDR_W-1:0]   fb_waddr;
   logic                fb_wdata;

   // Fullness comes from the registered count so a same-cycle pop cannot admit a push.
   assign full = (count_q == FULL_CNT);
   assign push = pixel_en & ~full;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      clr_cnt_d   = clr_cnt_q;
      scan_data_d = scan_data_q;
      oob_d       = oob_q;
      ovf_d       = ovf_q;
      pop         = 1'b0;
      fb_we       = 1'b0;
      fb_waddr    = clr_cnt_q;
      fb_wdata    = 1'b0;
      head_addr   = fifo_addr_q[rd_ptr_q];
      head_val    = fifo_val_q[rd_ptr_q];

      // Scanout owns the RAM port outright; clear and drain only see idle cycles.
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (!scan_en && (count_q != '0)) begin
               pop = 1'b1;
               if (head_addr < FB_SIZE_W) begin
                  fb_we    = 1'b1;
                  fb_waddr = head_addr[ADDR_W-1:0];
                  fb_wdata = head_val;
               end else begin
                  oob_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (!scan_en) begin
               fb_we    = 1'b1;
               fb_waddr = clr_cnt_q;
               fb_wdata = 1'b0;
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d   = ST_IDLE;
                  clr_cnt_d = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pixel_en && full) begin
         ovf_d = 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (scan_en) begin
         scan_data_d = (scan_addr < FB_SIZE_A) ? fb_mem[scan_addr] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         clr_cnt_q   <= '0;
         scan_data_q <= 1'b0;
         oob_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         clr_cnt_q   <= clr_cnt_d;
         scan_data_q <= scan_data_d;
         oob_q       <= oob_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= pixel_addr;
         fifo_val_q[wr_ptr_q]  <= pixel_value;
      end
   end

   // Framebuffer is never reset; a reset cycle also suppresses any pending write.
   always_ff @(posedge clk) begin
      if (rst && fb_we) begin
         fb_mem[fb_waddr] <= fb_wdata;
      end
   end

   assign stall        = full;
   assign busy         = (state_q == ST_CLEAR);
   assign scan_data    = scan_data_q;
   assign fifo_count   = count_q;
   assign oob_err      = oob_q;
   assign overflow_err = ovf_q;

endmodule
`default_nettype wire
